// File: rtl/add_mul_seq_if.sv
// Operand/result bundle for add_mul_seq: the requester drives the operands and
// start, the sequencer returns the result, status and FSM visibility.
interface add_mul_seq_if #(
  parameter int WIDTH = 8,
  parameter int OUT_W = 2*WIDTH+2
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic [OUT_W-1:0] out;
  logic             done;
  logic             busy;
  logic [2:0]       state;
  logic [2:0]       nstate;

  modport master (
    output start, mode, A, B, C, D,
    input  out, done, busy, state, nstate
  );

  modport slave (
    input  start, mode, A, B, C, D,
    output out, done, busy, state, nstate
  );
endinterface

// File: rtl/add_mul_seq.sv
// Sequential unsigned arithmetic unit: (A+B)*(C+D) or A*B + C*D using one
// shared shift-add multiplier that retires one multiplier bit per cycle.
module add_mul_seq #(
  parameter int WIDTH = 8,
  parameter int OUT_W = 2*WIDTH+2
) (
  input logic         clk,
  input logic         rst,
  add_mul_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH+2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_MUL1 = 3'd2,
    S_MUL2 = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_nstate;
  logic             r_mode;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [WIDTH-1:0] r_d;
  logic [OUT_W-1:0] r_mcand;
  logic [WIDTH:0]   r_mplier;
  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] r_out;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_busy;
  logic [WIDTH:0]   w_s1;
  logic [WIDTH:0]   w_s2;
  logic [OUT_W-1:0] w_acc_nxt;
  logic             w_last;

  function automatic logic [OUT_W-1:0] mac_step(input logic [OUT_W-1:0] acc,
                                                input logic [OUT_W-1:0] mcand,
                                                input logic             bit0);
    return acc + (bit0 ? mcand : '0);
  endfunction

  assign w_s1      = {1'b0, r_a} + {1'b0, r_b};
  assign w_s2      = {1'b0, r_c} + {1'b0, r_d};
  assign w_acc_nxt = mac_step(r_acc, r_mcand, r_mplier[0]);
  assign w_last    = (r_cnt == CNT_W'(WIDTH));

  always_comb begin
    w_nstate = S_IDLE;
    if (!rst) begin
      case (r_state)
        S_IDLE:  w_nstate = bus.start ? S_ADD : S_IDLE;
        S_ADD:   w_nstate = S_MUL1;
        S_MUL1:  w_nstate = w_last ? (r_mode ? S_MUL2 : S_DONE) : S_MUL1;
        S_MUL2:  w_nstate = w_last ? S_DONE : S_MUL2;
        default: w_nstate = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    r_state <= w_nstate;
    r_done  <= (w_nstate == S_DONE);
    r_busy  <= (w_nstate != S_IDLE);
    if (rst) begin
      r_mode   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_d      <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_out    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mode <= bus.mode;
            r_a    <= bus.A;
            r_b    <= bus.B;
            r_c    <= bus.C;
            r_d    <= bus.D;
          end
        end
        S_ADD: begin
          r_cnt <= '0;
          r_acc <= '0;
          if (r_mode) begin
            r_mcand  <= OUT_W'(r_a);
            r_mplier <= {1'b0, r_b};
          end else begin
            r_mcand  <= OUT_W'(w_s1);
            r_mplier <= w_s2;
          end
        end
        S_MUL1, S_MUL2: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            // A*B stays in the accumulator; C*D is folded in during MUL2
            if (r_state == S_MUL1 && r_mode) begin
              r_mcand  <= OUT_W'(r_c);
              r_mplier <= {1'b0, r_d};
              r_cnt    <= '0;
            end else begin
              r_out <= w_acc_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out    = r_out;
  assign bus.done   = r_done;
  assign bus.busy   = r_busy;
  assign bus.state  = r_state;
  assign bus.nstate = w_nstate;
endmodule

// File: tb/tb_add_mul_seq.sv
// Self-checking bench for add_mul_seq (WIDTH=8): directed cases, randomized
// operations against an arithmetic reference, and protocol monitoring.
module tb_add_mul_seq;
  localparam int W     = 8;
  localparam int OUT_W = 2*W+2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  int   cyc = 0;
  int   n_done = 0;
  int   nst_err = 0;
  int   dwid_err = 0;
  bit   mon_on = 1'b0;
  logic [2:0] pnst;
  logic pdone;

  add_mul_seq_if #(.WIDTH(W), .OUT_W(OUT_W)) bus ();

  add_mul_seq #(.WIDTH(W), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Records protocol observations each cycle: nstate prediction and done width
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.state !== pnst) nst_err++;
      if (bus.done === 1'b1 && pdone === 1'b1) dwid_err++;
    end
    if (bus.done === 1'b1) n_done++;
    pnst   = bus.nstate;
    pdone  = bus.done;
    mon_on = 1'b1;
    cyc++;
  end

  function automatic int unsigned model(input bit m, input int unsigned a, b, c, d);
    return m ? (a*b + c*d) : ((a+b)*(c+d));
  endfunction

  function automatic int model_lat(input bit m);
    return m ? (2*W+4) : (W+3);
  endfunction

  // inj: 0 quiet inputs, 1 random input churn while busy, 2 start pulse 5,6,7,8 in MUL1
  task automatic run_op(input bit m, input int unsigned a, b, c, d, input int inj,
                        output int unsigned res, output int lat, output int bbad,
                        output int t0);
    bus.mode  = m;
    bus.A     = 8'(a);
    bus.B     = 8'(b);
    bus.C     = 8'(c);
    bus.D     = 8'(d);
    bus.start = 1'b1;
    t0        = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat  = 1;
    bbad = 0;
    forever begin
      @(negedge clk);
      if (bus.busy !== 1'b1) bbad++;
      if (bus.done === 1'b1) break;
      if (lat > 60) begin
        lat = -1;
        break;
      end
      @(posedge clk); #1;
      lat++;
      if (inj == 1) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.mode  = 1'($urandom_range(0, 1));
        bus.A     = 8'($urandom);
        bus.B     = 8'($urandom);
        bus.C     = 8'($urandom);
        bus.D     = 8'($urandom);
      end else if (inj == 2 && lat == 3) begin
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        bus.A     = 8'd5;
        bus.B     = 8'd6;
        bus.C     = 8'd7;
        bus.D     = 8'd8;
      end else begin
        bus.start = 1'b0;
      end
    end
    res = int'(bus.out);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b1; bus.mode = 1'b1;
    bus.A = 8'd3; bus.B = 8'd4; bus.C = 8'd5; bus.D = 8'd6;
    @(negedge clk);
    total++;
    if (bus.nstate !== 3'd0) begin
      bad++; $display("FAIL reset_nstate got=%0d want=0", bus.nstate);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (bus.state !== 3'd0 || bus.out !== '0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got state=%0d out=%0d done=%b busy=%b want 0/0/0/0",
               bus.state, bus.out, bus.done, bus.busy);
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus.state !== 3'd0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL reset_start_ignored got state=%0d busy=%b want 0/0", bus.state, bus.busy);
    end
  endtask

  task automatic test_directed();
    int unsigned res;
    int lat, bbad, t0;
    run_op(1'b0, 1, 2, 3, 4, 0, res, lat, bbad, t0);
    total++;
    if (res !== 21 || lat !== 11 || bbad !== 0) begin
      bad++; $display("FAIL dir_1234 got out=%0d lat=%0d busylow=%0d want 21/11/0", res, lat, bbad);
    end
    run_op(1'b0, 255, 255, 255, 255, 0, res, lat, bbad, t0);
    total++;
    if (res !== 260100 || lat !== 11) begin
      bad++; $display("FAIL dir_max_m0 got out=%0d lat=%0d want 260100/11", res, lat);
    end
    run_op(1'b1, 255, 255, 255, 255, 0, res, lat, bbad, t0);
    total++;
    if (res !== 130050 || lat !== 20 || bbad !== 0) begin
      bad++; $display("FAIL dir_max_m1 got out=%0d lat=%0d busylow=%0d want 130050/20/0", res, lat, bbad);
    end
    run_op(1'b1, 9, 1, 2, 3, 0, res, lat, bbad, t0);
    total++;
    if (res !== 15 || lat !== 20) begin
      bad++; $display("FAIL dir_9123 got out=%0d lat=%0d want 15/20", res, lat);
    end
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (bus.out !== OUT_W'(15) || bus.state !== 3'd0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL out_hold got out=%0d state=%0d done=%b want 15/0/0", bus.out, bus.state, bus.done);
    end
  endtask

  task automatic test_ignore_start();
    int unsigned res;
    int lat, bbad, t0, n0;
    n0 = n_done;
    run_op(1'b0, 1, 2, 3, 4, 2, res, lat, bbad, t0);
    repeat (25) begin @(posedge clk); #1; end
    total++;
    if (res !== 21 || lat !== 11 || (n_done - n0) !== 1 || bus.out !== OUT_W'(21)) begin
      bad++;
      $display("FAIL ignore_start got out=%0d lat=%0d pulses=%0d want 21/11/1", res, lat, n_done - n0);
    end
  endtask

  task automatic test_random();
    int unsigned a, b, c, d, res, exp;
    int lat, bbad, t0, errs;
    bit m;
    errs = 0;
    for (int i = 0; i < 24; i++) begin
      m = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 255); b = $urandom_range(0, 255);
      c = $urandom_range(0, 255); d = $urandom_range(0, 255);
      if (i < 4) begin a = (i % 2) ? 255 : 0; b = 255; c = (i < 2) ? 0 : 255; d = 1; end
      exp = model(m, a, b, c, d);
      run_op(m, a, b, c, d, (i % 3 == 0) ? 0 : 1, res, lat, bbad, t0);
      total++;
      if (res !== exp || lat !== model_lat(m) || bbad !== 0) begin
        bad++;
        $display("FAIL rand_%0d m=%0d %0d,%0d,%0d,%0d got out=%0d lat=%0d want out=%0d lat=%0d busylow=%0d",
                 i, m, a, b, c, d, res, lat, exp, model_lat(m), bbad);
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned r1, r2;
    int l1, l2, b1, b2, t1, t2;
    run_op(1'b1, 10, 20, 30, 40, 0, r1, l1, b1, t1);
    run_op(1'b0, 7, 8, 9, 10, 0, r2, l2, b2, t2);
    total++;
    if (r1 !== model(1'b1, 10, 20, 30, 40) || r2 !== model(1'b0, 7, 8, 9, 10)) begin
      bad++; $display("FAIL b2b_results got %0d,%0d want 1400,285", r1, r2);
    end
    total++;
    if ((t2 - t1) !== model_lat(1'b1) + 1 || l2 !== model_lat(1'b0)) begin
      bad++; $display("FAIL b2b_spacing got gap=%0d lat2=%0d want %0d/%0d", t2 - t1, l2, model_lat(1'b1) + 1, model_lat(1'b0));
    end
  endtask

  task automatic test_rst_abort();
    int unsigned res;
    int lat, bbad, t0, n0;
    bus.mode = 1'b1; bus.A = 8'd5; bus.B = 8'd6; bus.C = 8'd7; bus.D = 8'd8;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (W+3) begin @(posedge clk); #1; end
    total++;
    if (bus.state !== 3'd3) begin
      bad++; $display("FAIL abort_in_mul2 got state=%0d want 3", bus.state);
    end
    n0 = n_done;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (bus.state !== 3'd0 || bus.out !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL abort_state got state=%0d out=%0d busy=%b done=%b want 0/0/0/0",
               bus.state, bus.out, bus.busy, bus.done);
    end
    repeat (25) begin @(posedge clk); #1; end
    total++;
    if ((n_done - n0) !== 0 || bus.out !== '0) begin
      bad++; $display("FAIL abort_no_done got pulses=%0d out=%0d want 0/0", n_done - n0, bus.out);
    end
    run_op(1'b0, 5, 6, 7, 8, 0, res, lat, bbad, t0);
    total++;
    if (res !== 165 || lat !== 11) begin
      bad++; $display("FAIL abort_restart got out=%0d lat=%0d want 165/11", res, lat);
    end
  endtask

  task automatic test_protocol();
    total++;
    if (nst_err !== 0) begin
      bad++; $display("FAIL nstate_predict got errors=%0d want 0", nst_err);
    end
    total++;
    if (dwid_err !== 0) begin
      bad++; $display("FAIL done_width got errors=%0d want 0", dwid_err);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = 1'b0;
    bus.A = '0; bus.B = '0; bus.C = '0; bus.D = '0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_random();
    test_back_to_back();
    test_rst_abort();
    repeat (2) begin @(posedge clk); #1; end
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/add_mul_seq.md
ADD_MUL_SEQ -- requirements
Module: add_mul_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (legal range 2..16).
REQ-002 Parameter: OUT_W, default 2*WIDTH+2, result width; SHALL NOT be overridden below 2*WIDTH+2.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 Port: mode  input  1  0: (A+B)*(C+D); 1: A*B + C*D; sampled with start.
REQ-007 Port: A, B, C, D  input  WIDTH each  unsigned operands; sampled with start.
REQ-008 Port: out  output  OUT_W  registered unsigned result.
REQ-009 Port: done  output  1  high for exactly one cycle when out is updated.
REQ-010 Port: busy  output  1  high whenever state is not IDLE.
REQ-011 Port: state  output  3  current FSM state encoding.
REQ-012 Port: nstate  output  3  combinational next-state encoding.

Function
REQ-013 FSM states, fixed encoding: IDLE=0, ADD=1, MUL1=2, MUL2=3, DONE=4; codes 5-7 SHALL go to IDLE next cycle.
REQ-014 IDLE: start=1 -> capture A,B,C,D,mode into internal registers, go ADD; start=0 -> stay IDLE.
REQ-015 ADD, mode 0: form S1=A+B and S2=C+D, each WIDTH+1 bits, no truncation; go MUL1.
REQ-016 ADD, mode 1: load multiplier operands A and B, zero-extended to WIDTH+1 bits; clear accumulator; go MUL1.
REQ-017 MUL1: shift-add multiply, one multiplier bit per cycle (LSB first); stays exactly WIDTH+1 cycles.
REQ-018 MUL1 exit: mode 0 -> DONE; mode 1 -> MUL2 with operands C and D loaded and A*B kept in accumulator.
REQ-019 MUL2: shift-add C*D added into the accumulator; exactly WIDTH+1 cycles; then DONE.
REQ-020 Arithmetic: all unsigned; accumulator OUT_W bits; no overflow possible at the default OUT_W.
REQ-021 out SHALL load the final result on the edge that enters DONE and hold it until the next entry into DONE or reset.
REQ-022 done = 1 iff state==DONE; DONE lasts one cycle, then IDLE.
REQ-023 Latency, start sampled in cycle k: mode 0 -> done in cycle k+WIDTH+3; mode 1 -> done in cycle k+2*WIDTH+4.
REQ-024 start while busy (ADD, MUL1, MUL2, DONE) SHALL be ignored; no queuing.
REQ-025 After DONE, start may be accepted in the following IDLE cycle; back-to-back throughput = latency+1 cycles.
REQ-026 Operand or mode changes after capture SHALL NOT affect the operation in flight.
REQ-027 nstate SHALL equal the value state takes on the next edge, rst included (rst=1 -> nstate=IDLE).

Reset
REQ-028 rst=1 at a rising edge -> state=IDLE, out=0, accumulator and operand registers=0; done=0, busy=0.
REQ-029 rst takes priority over start and aborts any operation in flight; no done pulse, out forced to 0.
REQ-030 start sampled in the same cycle as rst=1 SHALL be ignored.

Verification (WIDTH=8)
REQ-031 mode 0, A=1, B=2, C=3, D=4, start one cycle -> done in cycle k+11, out=21, busy high k+1..k+11.
REQ-032 mode 0, A=B=C=D=255 -> out=260100; then mode 1 with same operands -> out=130050 in cycle k+20.
REQ-033 mode 1, A=9, B=1, C=2, D=3 -> out=15 at done; out holds 15 through the following idle cycles.
REQ-034 start pulsed during MUL1 with new operands 5,6,7,8 -> ignored; first result unchanged; one done pulse only.
REQ-035 rst=1 mid-MUL2 -> next cycle state=0, out=0, busy=0, no done; fresh start 5,6,7,8, mode 0 -> out=165.
REQ-036 Every cycle of all scenarios: nstate equals the next cycle's state; done width is exactly one cycle.
